// File: rtl/car_sequence_gen.sv
// car_sequence_gen: emits the a/b photo-sensor waveforms of a programmable
// number of car passages (entry or exit) so the parking-lot counter can be
// exercised without real sensors. All outputs come straight from flops.
module car_sequence_gen #(
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir,
    input  logic [CNT_W-1:0]   n_cars,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [DWELL_W-1:0] gap,
    input  logic               abort,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cars_sent
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_GAP  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   n_cars_q, n_cars_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0]   cars_sent_q, cars_sent_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               phase_end;

    // A programmed length of zero behaves like one cycle.
    function automatic logic [DWELL_W-1:0] at_least_one(input logic [DWELL_W-1:0] v);
        return (v == '0) ? DWELL_W'(1) : v;
    endfunction

    // The countdown is on its last cycle when it reaches 1 (0 only after reset).
    assign phase_end = (cnt_q <= DWELL_W'(1));

    // Next-state, latched parameters and registered output values.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned; this is what keeps the block free of latches.
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        n_cars_d    = n_cars_q;
        dwell_d     = dwell_q;
        gap_d       = gap_q;
        cars_sent_d = cars_sent_q;
        done_d      = 1'b0;
        a_d         = 1'b0;
        b_d         = 1'b0;
        busy_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // abort sampled together with start discards the start
                if (start && !abort) begin
                    cars_sent_d = '0;
                    if (n_cars != '0) begin
                        dir_d    = dir;
                        n_cars_d = n_cars;
                        dwell_d  = dwell;
                        gap_d    = gap;
                        cnt_d    = at_least_one(dwell);
                        state_d  = S_P1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_P1: begin
                if (phase_end) begin
                    state_d = S_P2;
                    cnt_d   = at_least_one(dwell_q);
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            S_P2: begin
                if (phase_end) begin
                    state_d = S_P3;
                    cnt_d   = at_least_one(dwell_q);
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            S_P3: begin
                if (phase_end) begin
                    // a falls here, which is where the counter registers the car
                    state_d     = S_GAP;
                    cnt_d       = at_least_one(gap_q);
                    cars_sent_d = cars_sent_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    if (cars_sent_q < n_cars_q) begin
                        state_d = S_P1;
                        cnt_d   = at_least_one(dwell_q);
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Cancel: back to IDLE silently, the count of completed cars is kept.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            cars_sent_d = cars_sent_q;
            done_d      = 1'b0;
        end

        // Sensor levels are decoded from the next state so they land in flops.
        unique case (state_d)
            S_P1: begin
                a_d = ~dir_d;
                b_d = dir_d;
            end
            S_P2: begin
                a_d = 1'b1;
                b_d = 1'b1;
            end
            S_P3: begin
                a_d = 1'b1;
                b_d = 1'b0;
            end
            default: begin
                a_d = 1'b0;
                b_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and output flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            n_cars_q    <= '0;
            dwell_q     <= '0;
            gap_q       <= '0;
            cars_sent_q <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            n_cars_q    <= n_cars_d;
            dwell_q     <= dwell_d;
            gap_q       <= gap_d;
            cars_sent_q <= cars_sent_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cars_sent = cars_sent_q;

endmodule

// File: tb/tb_car_sequence_gen.sv
// Testbench for car_sequence_gen: per-cycle scoreboard of a/b/busy/done/
// cars_sent built from the passage description, a table of runs, a looped-back
// car counter model, and hand-written abort / reset / restart sequences.
module tb_car_sequence_gen;

    localparam int DWELL_W = 16;
    localparam int CNT_W   = 13;
    localparam int BUDGET  = 40000;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               dir = 1'b0;
    logic               abort = 1'b0;
    logic [CNT_W-1:0]   n_cars = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [DWELL_W-1:0] gap = '0;
    logic               a, b, busy, done;
    logic [CNT_W-1:0]   cars_sent;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cycles = 0;
    int ctr = 0;
    int cs = 0;

    typedef struct packed {
        logic             a;
        logic             b;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] cars;
    } obs_t;

    typedef struct {
        logic  dir;
        int    n;
        int    dwell;
        int    gap;
        int    exp_cars;
        int    exp_count;
        int    exp_busy;
        string name;
    } vec_t;

    obs_t sb[$];

    car_sequence_gen #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .n_cars    (n_cars),
        .dwell     (dwell),
        .gap       (gap),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .cars_sent (cars_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic ea, input logic eb, input logic ebusy,
                                input logic edone, input int cars);
        obs_t o;
        o.a    = ea;
        o.b    = eb;
        o.busy = ebusy;
        o.done = edone;
        o.cars = CNT_W'(cars);
        return o;
    endfunction

    // Expected per-cycle outputs of a full run, starting with the first P1 cycle.
    function automatic void push_trace(input logic d, input int n, input int dw, input int gp);
        int de = (dw == 0) ? 1 : dw;
        int ge = (gp == 0) ? 1 : gp;
        for (int k = 1; k <= n; k++) begin
            for (int i = 0; i < de; i++) sb.push_back(mk(~d, d, 1'b1, 1'b0, k - 1));
            for (int i = 0; i < de; i++) sb.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, k - 1));
            for (int i = 0; i < de; i++) sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, k - 1));
            for (int i = 0; i < ge; i++) sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, k));
        end
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, n));
    endfunction

    // Scoreboard consumer: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        obs_t e;
        if (busy === 1'b1) busy_cycles++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("trace", 32'({a, b, busy, done, cars_sent}), 32'(e));
        end
    end

    // Looped-back car counter: counts 10 -> 11 -> 10 -> 00 only.
    always @(negedge clk) begin
        case (cs)
            0: if ({a, b} == 2'b10) cs = 1;
            1: if ({a, b} == 2'b11) cs = 2;
               else if ({a, b} != 2'b10) cs = 0;
            2: if ({a, b} == 2'b10) cs = 3;
               else if ({a, b} != 2'b11) cs = 0;
            3: if ({a, b} == 2'b00) begin
                   cs = 0;
                   ctr++;
               end else if ({a, b} == 2'b11) cs = 2;
               else if ({a, b} != 2'b10) cs = 0;
            default: cs = 0;
        endcase
    end

    task automatic wait_drain(input string name);
        int c = 0;
        while (sb.size() != 0 && c < BUDGET) begin
            @(negedge clk);
            #1;
            c++;
        end
        check({name, "_drain_left"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic drive_start(input logic d, input int n, input int dw, input int gp,
                               input logic ab);
        @(negedge clk);
        start       = 1'b1;
        abort       = ab;
        dir         = d;
        n_cars      = CNT_W'(n);
        dwell       = DWELL_W'(dw);
        gap         = DWELL_W'(gp);
        busy_cycles = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int c0 = ctr;
        drive_start(v.dir, v.n, v.dwell, v.gap, 1'b0);
        push_trace(v.dir, v.n, v.dwell, v.gap);
        wait_drain(v.name);
        check({v.name, "_cars_sent"}, 32'(cars_sent), 32'(v.exp_cars));
        check({v.name, "_counter"}, 32'(ctr - c0), 32'(v.exp_count));
        check({v.name, "_busy_cycles"}, 32'(busy_cycles), 32'(v.exp_busy));
    endtask

    initial begin
        vec_t vecs[6];
        int   c0;

        vecs[0] = '{1'b0, 1, 2, 1, 1, 1, 7, "entry1"};
        vecs[1] = '{1'b1, 1, 3, 1, 1, 0, 10, "exit1"};
        vecs[2] = '{1'b0, 3, 0, 0, 3, 3, 12, "entry3"};
        vecs[3] = '{1'b0, 2, 1, 3, 2, 2, 12, "entry2_gap3"};
        vecs[4] = '{1'b1, 2, 2, 0, 2, 0, 14, "exit2"};
        vecs[5] = '{1'b0, 8191, 0, 0, 8191, 8191, 32764, "max_cars"};

        // Reset state
        #3;
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cars_sent", 32'(cars_sent), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // n_cars = 0: done next cycle, no activity, cars_sent cleared
        drive_start(1'b0, 0, 5, 5, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        wait_drain("zero_cars");

        // start while busy with different parameters is ignored
        c0 = ctr;
        drive_start(1'b0, 2, 2, 2, 1'b0);
        push_trace(1'b0, 2, 2, 2);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        dir    = 1'b1;
        n_cars = CNT_W'(5);
        dwell  = DWELL_W'(1);
        gap    = DWELL_W'(1);
        @(negedge clk);
        start = 1'b0;
        wait_drain("start_busy");
        check("start_busy_cars_sent", 32'(cars_sent), 32'd2);
        check("start_busy_counter", 32'(ctr - c0), 32'd2);

        // abort in the first P2 cycle of car 2
        c0 = ctr;
        drive_start(1'b0, 4, 2, 1, 1'b0);
        push_trace(1'b0, 4, 2, 1);
        while (sb.size() > 10) void'(sb.pop_back());
        for (int i = 0; i < 3; i++) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1));
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_drain("abort_p2");
        check("abort_counter", 32'(ctr - c0), 32'd1);

        // abort together with start in IDLE: nothing starts, cars_sent kept
        drive_start(1'b0, 3, 1, 1, 1'b1);
        for (int i = 0; i < 3; i++) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1));
        wait_drain("abort_start");

        // asynchronous reset in the middle of P1
        drive_start(1'b0, 2, 4, 1, 1'b0);
        sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 0));
        sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 0));
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_a", 32'(a), 32'd0);
        check("async_rst_b", 32'(b), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_cars_sent", 32'(cars_sent), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // normal run after reset release
        run_vec('{1'b0, 1, 2, 1, 1, 1, 7, "after_reset"});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
